ls7212_job_arbiter: RTL and testbench
=====================================

# ls7212_job_arbiter

Round-robin controller sharing one `delay_timer_ls7212` instance among `NREQ` requesters. Each requester supplies a weight (`wb`) and mode (`mode_a`/`mode_b`). The arbiter grants one job at a time, loads the timer configuration, and sequences the trigger against the timer's `delay_out_n`. It then reports per-requester completion and aborts hung jobs through a watchdog. It sits between the control logic and the timer, and owns the timer's `wb`, `mode_a`, `mode_b`, `trigger` and `reset` pins.

## Interface

Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `SETUP_CYC`, 2: cycles that `wb`/mode are held stable before `trigger` rises, ≥1.
- `TMO_CYC`, 1024: watchdog limit per phase, in cycles, ≥4.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  level request, one bit per requester.
- `req_wb`  in  8*NREQ  weight for requester i at bits `[8i+7:8i]`.
- `req_mode`  in  2*NREQ  `{mode_b,mode_a}` for requester i at bits `[2i+1:2i]`.
- `grant`  out  NREQ  one-hot; held for the whole job.
- `done`  out  NREQ  one-cycle pulse on the granted bit at job end (normal or abort).
- `err`  out  1  one-cycle pulse coincident with `done` when the job was aborted.
- `busy`  out  1  high in any state other than IDLE.
- `tmr_wb`  out  8  to timer `wb`.
- `tmr_mode_a`, `tmr_mode_b`  out  1 each  to timer mode pins.
- `tmr_trigger`  out  1  to timer `trigger`.
- `tmr_reset`  out  1  to timer `reset`, active-high.
- `tmr_out_n`  in  1  from timer `delay_out_n`; same clock domain, no synchronizer.

## Operation

- The FSM has five states: IDLE, LOAD, FIRE, RELEASE, ABORT. All outputs are registered.
- **IDLE:**
  - If any `req` bit is high, select the first set bit searching upward from `ptr`, wrapping at NREQ.
  - Latch the selected requester's `wb`/mode into `tmr_*`, set `grant`, then go to LOAD.
  - `ptr` becomes the selected index + 1, modulo NREQ.
- **LOAD:**
  - `tmr_trigger`=0.
  - Count `SETUP_CYC` cycles, then go to FIRE.
- **FIRE:**
  - `tmr_trigger`=1.
  - Go to RELEASE when `tmr_out_n` is sampled 0.
- **RELEASE:**
  - `tmr_trigger`=0.
  - When `tmr_out_n` is sampled 1, pulse `done[g]`, clear `grant` and go to IDLE.
- **ABORT:**
  - Entered when the watchdog expires in FIRE or RELEASE.
  - `tmr_trigger`=0 and `tmr_reset`=1 for exactly 2 cycles.
  - Then pulse `done[g]` and `err`, clear `grant` and go to IDLE.
- **Watchdog:** the counter is cleared on entry to FIRE and on entry to RELEASE. When it reaches `TMO_CYC-1`, the FSM goes to ABORT on the next edge.
- **Request handling:**
  - `req`, `req_wb` and `req_mode` are sampled only in IDLE.
  - Dropping `req` mid-job has no effect; the job runs to completion.
  - Keeping `req` high after `done` requests a new job, which is scheduled in round-robin order.
- **`tmr_*` hold:** `tmr_wb` and the mode outputs hold their last job's values in IDLE.

## Timing

- **Reset values:**
  - `grant`=0, `done`=0, `err`=0, `busy`=0.
  - `tmr_wb`=0, `tmr_mode_a`=0, `tmr_mode_b`=0, `tmr_trigger`=0.
  - `tmr_reset`=1; it deasserts on the first clock edge after `reset_n` rises.
  - `ptr`=0, state=IDLE.
- **Reset mid-job:** all outputs return to reset values immediately (asynchronous); no `done` is issued.
- **Job cycle sequence,** with `req` high at edge t while in IDLE:
  - `grant` and `tmr_*` are valid after edge t.
  - `tmr_trigger` rises after edge t+`SETUP_CYC`.
  - `tmr_trigger` falls one edge after `tmr_out_n` is sampled 0.
  - `done` is asserted one edge after `tmr_out_n` is sampled 1.
- **Back-to-back jobs:** at least one IDLE cycle between jobs, so the next `grant` appears 1 cycle after `done`.
- **Already-low `tmr_out_n`:** if `tmr_out_n` is 0 on the first FIRE cycle, FIRE lasts exactly 1 cycle.
- **Simultaneous conditions:**
  - In FIRE or RELEASE, a valid `tmr_out_n` transition takes priority over watchdog expiry.
  - In IDLE, multiple request bits resolve by `ptr` order only.

## Configuration

- Macro `LS7212_ARB_WDOG_EN`:
  - Defined: the watchdog and ABORT state are built as described.
  - Undefined: there is no counter, no ABORT state, and `err` is tied 0. FIRE and RELEASE wait indefinitely, and `tmr_reset` is 1 only during reset.

## Structure

- **Package `ls7212_pkg`:**
  - FSM state enum.
  - Mode encoding constants for the timer `{mode_b,mode_a}` values.
  - Width constant for `wb` (8).
  - Helper function `clog2`, used to size the watchdog counter.
- **Sub-module `ls7212_rr_pick`:** combinational round-robin picker. Inputs `req` and `ptr`; outputs a one-hot grant and the index.

## Test plan

- **Single job:** `req[0]`=1, `wb`=10, mode=2'b10; timer model drives `tmr_out_n` 0 at FIRE+5 and 1 at RELEASE+3.
  - Expect `tmr_trigger` high after 2 LOAD cycles.
  - Expect one `done[0]` pulse and `err`=0.
- **Round robin:** `req`=4'b1111 held.
  - Expect grant order 0,1,2,3,0.
  - Expect one IDLE cycle between each `done` and the next `grant`.
- **Request dropped mid-job:** `req[2]` drops during FIRE.
  - Expect the job to complete and `done[2]` to pulse.
  - Expect `tmr_wb` to stay at the latched value throughout.
- **Watchdog (macro on):** `tmr_out_n` held 1.
  - Expect ABORT at FIRE+1024 cycles.
  - Expect `tmr_reset`=1 for 2 cycles, then `done`+`err` pulse.
  - With the macro off, expect `busy` to stay 1.
- **Reset mid-RELEASE:** drop `reset_n`.
  - Expect `grant`=0, `tmr_trigger`=0 and `tmr_reset`=1 immediately, with no `done`.
  - After release, expect `tmr_reset`=0 after one edge and `ptr`=0.
- **Immediate low:** `tmr_out_n` already 0 when FIRE is entered.
  - Expect FIRE to last exactly 1 cycle.

Source files
------------

// File: rtl/ls7212_pkg.sv
// ls7212_pkg: shared FSM state, timer mode codes and sizing helper for the ls7212 job arbiter
package ls7212_pkg;
  localparam int WB_W = 8;
  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_A = 2'b01;
  localparam logic [1:0] MODE_B = 2'b10;
  localparam logic [1:0] MODE_AB = 2'b11;
`ifdef LS7212_ARB_WDOG_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FIRE, S_RELEASE, S_ABORT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FIRE, S_RELEASE} state_t;
`endif
  function automatic int clog2(input int v);
    int r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ls7212_job_arbiter_rr_pick.sv
// ls7212_rr_pick: combinational round-robin picker, first set req bit at or above ptr (wrapping)
module ls7212_rr_pick
  import ls7212_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]          req,
  input  logic [clog2(NREQ)-1:0]   ptr,
  output logic [NREQ-1:0]          grant,
  output logic [clog2(NREQ)-1:0]   idx
);
  localparam int PW = clog2(NREQ);
  int j;
  // descending scan so the candidate closest to ptr is written last and wins
  always_comb begin
    grant = '0;
    idx = '0;
    j = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = PW'(j);
      end
    end
  end
endmodule

// File: rtl/ls7212_job_arbiter.sv
// ls7212_job_arbiter: round-robin sharing of one delay_timer_ls7212 among NREQ requesters.
// Define LS7212_ARB_WDOG_EN to build the per-phase watchdog and ABORT state.
module ls7212_job_arbiter
  import ls7212_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int SETUP_CYC = 2,
  parameter int TMO_CYC = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_wb,
  input  logic [2*NREQ-1:0]   req_mode,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     done,
  output logic                err,
  output logic                busy,
  output logic [WB_W-1:0]     tmr_wb,
  output logic                tmr_mode_a,
  output logic                tmr_mode_b,
  output logic                tmr_trigger,
  output logic                tmr_reset,
  input  logic                tmr_out_n
);
  localparam int PW = clog2(NREQ);
  localparam int CW = clog2(SETUP_CYC + 1);
  state_t state, state_n;
  logic [PW-1:0] ptr, ptr_n, pick_idx;
  logic [NREQ-1:0] pick_oh, grant_n, done_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WB_W-1:0] wb_n;
  logic err_n, busy_n, ma_n, mb_n, trig_n, trst_n;
`ifdef LS7212_ARB_WDOG_EN
  localparam int WW = clog2(TMO_CYC);
  logic [WW-1:0] wd, wd_n;
  logic wd_exp;
  assign wd_exp = wd == WW'(TMO_CYC - 1);
`endif

  ls7212_rr_pick #(.NREQ(NREQ)) u_pick (
    .req(req),
    .ptr(ptr),
    .grant(pick_oh),
    .idx(pick_idx)
  );

  always_comb begin
    state_n = state;
    ptr_n = ptr;
    cnt_n = cnt;
    grant_n = grant;
    done_n = '0;
    err_n = 1'b0;
    wb_n = tmr_wb;
    ma_n = tmr_mode_a;
    mb_n = tmr_mode_b;
    trig_n = 1'b0;
    trst_n = 1'b0;
`ifdef LS7212_ARB_WDOG_EN
    wd_n = wd + 1'b1;
`endif
    case (state)
      S_IDLE: if (|req) begin
        state_n = S_LOAD;
        grant_n = pick_oh;
        cnt_n = '0;
        ptr_n = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        wb_n = req_wb[int'(pick_idx) * WB_W +: WB_W];
        {mb_n, ma_n} = req_mode[int'(pick_idx) * 2 +: 2];
      end
      S_LOAD: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(SETUP_CYC - 1)) begin
          state_n = S_FIRE;
          trig_n = 1'b1;
`ifdef LS7212_ARB_WDOG_EN
          wd_n = '0;
`endif
        end
      end
      // a timer edge seen in the same cycle as expiry still counts as progress
      S_FIRE: begin
        trig_n = 1'b1;
        if (!tmr_out_n) begin
          state_n = S_RELEASE;
          trig_n = 1'b0;
`ifdef LS7212_ARB_WDOG_EN
          wd_n = '0;
        end else if (wd_exp) begin
          state_n = S_ABORT;
          trig_n = 1'b0;
          trst_n = 1'b1;
          cnt_n = '0;
`endif
        end
      end
      S_RELEASE: begin
        if (tmr_out_n) begin
          state_n = S_IDLE;
          done_n = grant;
          grant_n = '0;
`ifdef LS7212_ARB_WDOG_EN
        end else if (wd_exp) begin
          state_n = S_ABORT;
          trst_n = 1'b1;
          cnt_n = '0;
`endif
        end
      end
`ifdef LS7212_ARB_WDOG_EN
      S_ABORT: begin
        trst_n = 1'b1;
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(1)) begin
          state_n = S_IDLE;
          trst_n = 1'b0;
          done_n = grant;
          err_n = 1'b1;
          grant_n = '0;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
    busy_n = state_n != S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      ptr <= '0;
      cnt <= '0;
      grant <= '0;
      done <= '0;
      err <= 1'b0;
      busy <= 1'b0;
      tmr_wb <= '0;
      tmr_mode_a <= 1'b0;
      tmr_mode_b <= 1'b0;
      tmr_trigger <= 1'b0;
      tmr_reset <= 1'b1;
`ifdef LS7212_ARB_WDOG_EN
      wd <= '0;
`endif
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      grant <= grant_n;
      done <= done_n;
      err <= err_n;
      busy <= busy_n;
      tmr_wb <= wb_n;
      tmr_mode_a <= ma_n;
      tmr_mode_b <= mb_n;
      tmr_trigger <= trig_n;
      tmr_reset <= trst_n;
`ifdef LS7212_ARB_WDOG_EN
      wd <= wd_n;
`endif
    end
  end
endmodule

// File: tb/tb_ls7212_job_arbiter.sv
// tb_ls7212_job_arbiter: directed self-checking bench; expected job completions are queued at request time
module tb_ls7212_job_arbiter;
  import ls7212_pkg::*;
  localparam int NREQ = 4;
  localparam int TMO = 1024;

  typedef struct {
    int idx;
    bit err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [8*NREQ-1:0] req_wb = '0;
  logic [2*NREQ-1:0] req_mode = '0;
  logic [NREQ-1:0] grant, done;
  logic err, busy, tmr_mode_a, tmr_mode_b, tmr_trigger, tmr_reset;
  logic [7:0] tmr_wb;
  logic tmr_out_n = 1'b1;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ls7212_job_arbiter #(.NREQ(NREQ), .SETUP_CYC(2), .TMO_CYC(TMO)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .req_wb(req_wb),
    .req_mode(req_mode),
    .grant(grant),
    .done(done),
    .err(err),
    .busy(busy),
    .tmr_wb(tmr_wb),
    .tmr_mode_a(tmr_mode_a),
    .tmr_mode_b(tmr_mode_b),
    .tmr_trigger(tmr_trigger),
    .tmr_reset(tmr_reset),
    .tmr_out_n(tmr_out_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_trig(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tmr_trigger && n < budget);
    chk("trig_seen", 32'(tmr_trigger), 1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    exp_t e;
    do begin
      @(negedge clk);
      n++;
    end while (done == '0 && n < budget);
    chk("done_seen", 32'(|done), 1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("done_vec", 32'(done), 32'(1) << e.idx);
      chk("err", 32'(err), 32'(e.err));
    end
  endtask

  initial begin
    int cnt;
    tick(2);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wb", 32'(tmr_wb), 0);
    chk("rst_mode", 32'({tmr_mode_b, tmr_mode_a}), 0);
    chk("rst_trig", 32'(tmr_trigger), 0);
    chk("rst_treset", 32'(tmr_reset), 1);
    reset_n = 1'b1;
    #1 chk("treset_hold", 32'(tmr_reset), 1);
    tick(1);
    chk("treset_rel", 32'(tmr_reset), 0);

    // single job: wb=10, mode b
    req_wb[7:0] = 8'd10;
    req_mode[1:0] = MODE_B;
    req = 4'b0001;
    sb.push_back('{0, 1'b0});
    tick(1);
    chk("j1_grant", 32'(grant), 1);
    chk("j1_wb", 32'(tmr_wb), 10);
    chk("j1_mode", 32'({tmr_mode_b, tmr_mode_a}), 32'(MODE_B));
    chk("j1_busy", 32'(busy), 1);
    chk("j1_trig_l0", 32'(tmr_trigger), 0);
    req = '0;
    tick(1);
    chk("j1_trig_l1", 32'(tmr_trigger), 0);
    tick(1);
    chk("j1_trig_fire", 32'(tmr_trigger), 1);
    tick(5);
    chk("j1_trig_hold", 32'(tmr_trigger), 1);
    tmr_out_n = 1'b0;
    tick(1);
    chk("j1_trig_fall", 32'(tmr_trigger), 0);
    tick(2);
    chk("j1_no_early_done", 32'(done), 0);
    tmr_out_n = 1'b1;
    wait_done(1);
    chk("j1_grant_clr", 32'(grant), 0);
    tick(1);
    chk("j1_done_pulse", 32'(done), 0);
    chk("j1_idle", 32'(busy), 0);
    chk("j1_wb_hold", 32'(tmr_wb), 10);

    // reset during RELEASE: no done, ptr back to 0
    req_wb[15:8] = 8'h55;
    req_mode[3:2] = MODE_A;
    req = 4'b0010;
    tick(1);
    chk("rs_grant", 32'(grant), 2);
    req = '0;
    wait_trig(10);
    tmr_out_n = 1'b0;
    tick(1);
    chk("rs_in_release", 32'(tmr_trigger), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rs_grant0", 32'(grant), 0);
    chk("rs_trig0", 32'(tmr_trigger), 0);
    chk("rs_treset", 32'(tmr_reset), 1);
    chk("rs_done0", 32'(done), 0);
    chk("rs_busy0", 32'(busy), 0);
    tmr_out_n = 1'b1;
    tick(2);
    chk("rs_no_done", 32'(done), 0);
    reset_n = 1'b1;
    tick(1);
    chk("rs_treset_rel", 32'(tmr_reset), 0);
    chk("rs_no_done2", 32'(done), 0);

    // round robin with all requests held
    for (int i = 0; i < NREQ; i++) begin
      req_wb[8*i +: 8] = 8'(8'h20 + i);
      req_mode[2*i +: 2] = 2'(i);
    end
    for (int k = 0; k < 5; k++) sb.push_back('{k % NREQ, 1'b0});
    req = 4'b1111;
    tick(1);
    chk("rr_grant_first", 32'(grant), 1);
    for (int k = 0; k < 5; k++) begin
      chk("rr_wb", 32'(tmr_wb), 32'(8'h20 + (k % NREQ)));
      chk("rr_mode", 32'({tmr_mode_b, tmr_mode_a}), 32'(k % NREQ));
      wait_trig(10);
      tmr_out_n = 1'b0;
      tick(1);
      tmr_out_n = 1'b1;
      wait_done(3);
      chk("rr_gap_grant", 32'(grant), 0);
      if (k == 4) req = '0;
      tick(1);
      if (k < 4) chk("rr_grant", 32'(grant), 32'(1) << ((k + 1) % NREQ));
    end
    chk("rr_end_idle", 32'(busy), 0);

    // request dropped mid-job; latched wb must not follow the inputs
    req_wb[23:16] = 8'h77;
    req_mode[5:4] = MODE_AB;
    req = 4'b0100;
    sb.push_back('{2, 1'b0});
    tick(1);
    chk("dr_grant", 32'(grant), 4);
    chk("dr_wb", 32'(tmr_wb), 8'h77);
    wait_trig(10);
    req = '0;
    req_wb[23:16] = 8'h00;
    tick(2);
    chk("dr_wb_fire", 32'(tmr_wb), 8'h77);
    chk("dr_grant_hold", 32'(grant), 4);
    tmr_out_n = 1'b0;
    tick(1);
    chk("dr_wb_rel", 32'(tmr_wb), 8'h77);
    tmr_out_n = 1'b1;
    wait_done(3);
    chk("dr_wb_idle", 32'(tmr_wb), 8'h77);

    // timer already low when FIRE starts
    tmr_out_n = 1'b0;
    req = 4'b1000;
    sb.push_back('{3, 1'b0});
    tick(1);
    chk("il_grant", 32'(grant), 8);
    req = '0;
    wait_trig(10);
    tick(1);
    chk("il_fire_one", 32'(tmr_trigger), 0);
    chk("il_busy", 32'(busy), 1);
    tmr_out_n = 1'b1;
    wait_done(3);

    // hung timer
    req = 4'b0001;
    tick(1);
    chk("wd_grant", 32'(grant), 1);
    req = '0;
`ifdef LS7212_ARB_WDOG_EN
    sb.push_back('{0, 1'b1});
    wait_trig(10);
    tick(TMO - 1);
    chk("wd_fire_last", 32'(tmr_trigger), 1);
    chk("wd_treset0", 32'(tmr_reset), 0);
    tick(1);
    chk("wd_abort_trig", 32'(tmr_trigger), 0);
    chk("wd_abort_rst1", 32'(tmr_reset), 1);
    chk("wd_abort_nodone", 32'(done), 0);
    tick(1);
    chk("wd_abort_rst2", 32'(tmr_reset), 1);
    chk("wd_abort_nodone2", 32'(done), 0);
    wait_done(1);
    chk("wd_treset_end", 32'(tmr_reset), 0);
    tick(1);
    chk("wd_err_pulse", 32'(err), 0);
    chk("wd_idle", 32'(busy), 0);
`else
    cnt = 0;
    for (int i = 0; i < TMO + 16; i++) begin
      @(negedge clk);
      if (!busy || done != '0 || tmr_reset) cnt++;
    end
    chk("nowd_stays_busy", 32'(cnt), 0);
    chk("nowd_err", 32'(err), 0);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
`endif
    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
